// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor d = a - b, LSB-first, one bit per clock, with start/busy/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp the difference to zero whenever the final borrow is set.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         busy,
    output logic         done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  sa, sb, res, res_nx;
    logic [CW-1:0] cnt;
    logic          br, br_nx, r, last;

    function automatic logic diff_bit(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic borrow_out(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    function automatic logic [W-1:0] final_result(input logic [W-1:0] v, input logic borrow);
`ifdef SERIAL_SUB_SAT_EN
        return borrow ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        r      = diff_bit(sa[0], sb[0], br);
        br_nx  = borrow_out(sa[0], sb[0], br);
        res_nx = {r, res[W-1:1]};
        last   = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            res <= '0;
            cnt <= '0;
            br  <= 1'b0;
            d   <= '0;
            bo  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    sa  <= a;
                    sb  <= b;
                    res <= '0;
                    cnt <= '0;
                    br  <= 1'b0;
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_nx;
                    br  <= br_nx;
                    cnt <= cnt + CW'(1);
                    // res_nx already holds all W difference bits on the last step
                    if (last) begin
                        d  <= final_result(res_nx, br_nx);
                        bo <= br_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (W = 8), immediate assertions at every check point.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b, d;
    logic         bo, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_sub #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .d(d), .bo(bo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done with a cycle budget; returns the number of edges taken.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic ebo);
        int n;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        wait_done(n);
        check({tag, "_latency"}, n, W);
        check({tag, "_d"}, d, ed);
        check({tag, "_bo"}, bo, ebo);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int  n, t0, seen;
        logic [W-1:0] exp_d;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bo", bo, 0);

        run_op("0f_03", 8'h0F, 8'h03, 8'h0C, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
        run_op("03_0f", 8'h03, 8'h0F, 8'h00, 1'b1);
        exp_d = 8'h00;
`else
        run_op("03_0f", 8'h03, 8'h0F, 8'hF4, 1'b1);
        exp_d = 8'hFF;
`endif
        run_op("00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("00_01", 8'h00, 8'h01, exp_d, 1'b1);
        run_op("aa_55", 8'hAA, 8'h55, 8'h55, 1'b0);

        // start held high and operands scrambled throughout RUN
        a = 8'h40; b = 8'h01; start = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            n++;
        end
        check("hold_latency", n, W);
        check("hold_d", d, 8'h3F);
        check("hold_bo", bo, 0);
        a = 8'h40; b = 8'h01;
        tick();
        check("hold_back_to_idle", busy, 0);
        tick();
        start = 1'b0;
        check("hold_second_starts", busy, 1);
        wait_done(n);
        check("hold_second_latency", n, W);
        check("hold_second_d", d, 8'h3F);
        tick();

        // reset during RUN cycle 4 discards the partial result
        a = 8'h80; b = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_d", d, 0);
        check("mrst_bo", bo, 0);
        seen = 0;
        repeat (W + 2) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("mrst_no_done", seen, 0);
        run_op("80_10", 8'h80, 8'h10, 8'h70, 1'b0);

        // back-to-back, start in first IDLE cycle after done
        a = 8'h05; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("b2b1_d", d, 8'h03);
        check("b2b1_bo", bo, 0);
        t0 = cyc;
        tick();
        a = 8'h02; b = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
`ifdef SERIAL_SUB_SAT_EN
        check("b2b2_d", d, 8'h00);
`else
        check("b2b2_d", d, 8'hFD);
`endif
        check("b2b2_bo", bo, 1);
        check("b2b_spacing", cyc - t0, W + 2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
